// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a hold counter that
// bounds how long one requester may keep the resource while others wait.
module onehot_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    localparam int unsigned HCW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam int unsigned CW        = IDW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]     state;
    logic [0:0]     state_n;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_n;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_n;
    logic [N-1:0]   grant_n;
    logic [IDW-1:0] grant_id_n;
    logic           grant_valid_n;

    logic           found;
    logic [IDW-1:0] pick;
    logic [CW-1:0]  cand;
    logic           issue;

    // First set request bit at or after ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = {1'b0, ptr} + CW'(off);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    // Next-state and next-output decision.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_n     = hold_cnt;
        grant_n    = grant;
        grant_id_n = grant_id;
        issue      = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    issue = 1'b1;
                end
            end
            GRANT: begin
                if (!req[grant_id]) begin
                    if (found) begin
                        issue = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        grant_n    = '0;
                        grant_id_n = '0;
                        hold_n     = '0;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt == HCW'(HOLD_LAST)) begin
                    // ptr already sits past the owner, so the owner is searched last
                    issue = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + HCW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (issue) begin
            state_n    = GRANT;
            grant_n    = N'(1) << pick;
            grant_id_n = pick;
            hold_n     = '0;
            ptr_n      = (pick == IDW'(N - 1)) ? '0 : pick + IDW'(1);
        end

        grant_valid_n = (state_n == GRANT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            grant_valid <= grant_valid_n;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed table, hand-written corner sequences,
// and randomized requests checked against a rule-level reference model.
module tb_onehot_rr_arbiter;

    localparam int NR  = 4;
    localparam int MH  = 4;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    onehot_rr_arbiter #(.N(NR), .MAX_HOLD(MH), .IDW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner (-1 when idle), priority pointer, hold cycles so far.
    int m_owner;
    int m_ptr;
    int m_hold;
    int waitc [NR];
    int max_wait;

    typedef struct packed {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
        logic [IW-1:0] exp_id;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [NR-1:0] r, input logic [NR-1:0] g, input logic [IW-1:0] id);
        vec_t v;
        v.req       = r;
        v.exp_grant = g;
        v.exp_id    = id;
        tbl.push_back(v);
    endtask

    function automatic int m_search(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            logic [IW-1:0] j;
            j = IW'((p + i) % NR);
            if (r[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] m_grant();
        logic [NR-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner[IW-1:0]] = 1'b1;
        return g;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic m_step(input logic [NR-1:0] r);
        int k;
        k = m_search(r, m_ptr);
        if (m_owner < 0 || !r[m_owner[IW-1:0]] || m_hold == MH - 1) begin
            if (k >= 0) begin
                m_owner = k;
                m_ptr   = (k + 1) % NR;
            end else begin
                m_owner = -1;
            end
            m_hold = 0;
        end else begin
            m_hold++;
        end
    endtask

    task automatic sample(input string tag, input logic [NR-1:0] r);
        logic [IW-1:0] eid;
        eid = (m_owner < 0) ? '0 : m_owner[IW-1:0];
        check({tag, ".grant"}, 32'(grant), 32'(m_grant()));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, ".id"}, 32'(grant_id), 32'(eid));
        check({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
        check({tag, ".id_bit"}, 32'(!grant_valid || grant[grant_id]), 32'd1);
        check({tag, ".legal"}, 32'(grant & ~r), 32'd0);
    endtask

    task automatic cycle(input logic [NR-1:0] r, input string tag);
        @(negedge clk);
        req = r;
        @(posedge clk);
        m_step(r);
        #1;
        sample(tag, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        m_reset();
        #1;
        check("reset.grant", 32'(grant), 32'd0);
        check("reset.valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        m_reset();

        // Reset held with all requesting, then first grant goes to index 0.
        @(negedge clk);
        req = 4'b1111;
        @(posedge clk);
        #1;
        check("s1.rst_grant", 32'(grant), 32'd0);
        check("s1.rst_valid", 32'(grant_valid), 32'd0);
        check("s1.rst_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        m_step(4'b1111);
        #1;
        sample("s1", 4'b1111);
        check("s1.first_grant", 32'(grant), 32'h1);
        check("s1.first_id", 32'(grant_id), 32'd0);
        check("s1.first_valid", 32'(grant_valid), 32'd1);

        // Lone requester keeps the grant across forced rotations with no gap.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0100, "s2");
            check("s2.solo_grant", 32'(grant), 32'h4);
            check("s2.solo_valid", 32'(grant_valid), 32'd1);
        end

        // Table: full rotation, idle, handoffs, wrap, forced rotation, release.
        add(4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < 20; i++) begin
            logic [IW-1:0] id;
            id = IW'((i / 4) % 4);
            add(4'b1111, 4'b0001 << id, id);
        end
        add(4'b0000, 4'b0000, 2'd0);
        add(4'b0100, 4'b0100, 2'd2);
        add(4'b1000, 4'b1000, 2'd3);
        add(4'b0011, 4'b0001, 2'd0);
        add(4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < 4; i++) add(4'b0110, 4'b0010, 2'd1);
        add(4'b0110, 4'b0100, 2'd2);
        add(4'b0010, 4'b0010, 2'd1);
        add(4'b0000, 4'b0000, 2'd0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            req = v.req;
            @(posedge clk);
            m_step(v.req);
            #1;
            check($sformatf("tbl[%0d].grant", i), 32'(grant), 32'(v.exp_grant));
            check($sformatf("tbl[%0d].id", i), 32'(grant_id), 32'(v.exp_id));
            check($sformatf("tbl[%0d].valid", i), 32'(grant_valid), 32'(|v.exp_grant));
            check($sformatf("tbl[%0d].onehot", i), 32'($countones(grant) <= 1), 32'd1);
        end

        // Owner releases while another waits: direct handoff, no idle cycle.
        do_reset();
        cycle(4'b1001, "s4");
        check("s4.first", 32'(grant), 32'h1);
        cycle(4'b1001, "s4");
        check("s4.hold", 32'(grant), 32'h1);
        cycle(4'b1000, "s4");
        check("s4.handoff_grant", 32'(grant), 32'h8);
        check("s4.handoff_id", 32'(grant_id), 32'd3);
        check("s4.handoff_valid", 32'(grant_valid), 32'd1);

        // Asynchronous reset mid-grant clears outputs and the pointer.
        do_reset();
        cycle(4'b0100, "s5");
        check("s5.pre", 32'(grant), 32'h4);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("s5.async_grant", 32'(grant), 32'd0);
        check("s5.async_valid", 32'(grant_valid), 32'd0);
        check("s5.async_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        req = 4'b0011;
        @(posedge clk);
        #1;
        check("s5.held", 32'(grant), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        m_step(4'b0011);
        #1;
        sample("s5", 4'b0011);
        check("s5.after", 32'(grant), 32'h1);

        // Randomized traffic against the model, with a starvation bound.
        do_reset();
        for (int i = 0; i < NR; i++) waitc[i] = 0;
        max_wait = 0;
        begin
            logic [NR-1:0] r;
            r = '0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(3) == 0) r = NR'($urandom);
                cycle(r, "rnd");
                for (int i = 0; i < NR; i++) begin
                    if (r[i] && !grant[i]) waitc[i]++;
                    else waitc[i] = 0;
                    if (waitc[i] > max_wait) max_wait = waitc[i];
                end
            end
        end
        check("fairness", 32'(max_wait <= (NR - 1) * MH), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
